// File: rtl/spi_master_if.sv
// Host handshake and SPI pin bundle for spi_master.
// The master modport is the controller's view; the slave modport is the host/pin side.
interface spi_master_if;
    logic       start;
    logic [1:0] cmd;
    logic [7:0] din;
    logic       busy;
    logic       done;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       SS_n;
    logic       MOSI;
    logic       MISO;

    modport master (
        input  start, cmd, din, MISO,
        output busy, done, rx_data, rx_valid, SS_n, MOSI
    );

    modport slave (
        output start, cmd, din, MISO,
        input  busy, done, rx_data, rx_valid, SS_n, MOSI
    );
endinterface

// File: rtl/spi_master.sv
// Frame serialiser for the shared-clock SPI slave: sends {cmd,din}, and for
// read-data frames collects the 8-bit reply from MISO after RD_LAT idle cycles.
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | SS_n high, waiting for start
// S_SEL   | SS_n low, slave leaves idle, MOSI = cmd[1]
// S_RW    | read/write decision bit (cmd[1]) presented to the slave
// S_SHIFT | 10 bits of {cmd,din}, MSB first
// S_WAIT  | RD_LAT idle cycles before the reply (read data only)
// S_RECV  | 8 reply bits shifted in from MISO, MSB first
// S_END   | SS_n high, done pulse, rx_data/rx_valid for read data
module spi_master #(
    parameter int RD_LAT = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    spi_master_if.master bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEL,
        S_RW,
        S_SHIFT,
        S_WAIT,
        S_RECV,
        S_END
    } state_t;

    localparam logic [3:0] SHIFT_LOAD = 4'd9;
    localparam logic [3:0] WAIT_LOAD  = 4'(RD_LAT - 1);
    localparam logic [3:0] RECV_LOAD  = 4'd7;

    state_t     state, state_nxt;
    logic [9:0] tx_sr, tx_sr_nxt;
    logic [3:0] cnt, cnt_nxt;
    logic       rd_frame, rd_frame_nxt;

    logic       ss_n_d, mosi_d, busy_d, done_d, rx_valid_d, load_rx;
    logic       ss_n_q, mosi_q, busy_q, done_q, rx_valid_q;
    logic [7:0] rx_data_q;
    logic [6:0] rx_sr;
    logic       recv_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            tx_sr    <= '0;
            cnt      <= '0;
            rd_frame <= 1'b0;
        end else begin
            state    <= state_nxt;
            tx_sr    <= tx_sr_nxt;
            cnt      <= cnt_nxt;
            rd_frame <= rd_frame_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        tx_sr_nxt    = tx_sr;
        cnt_nxt      = cnt;
        rd_frame_nxt = rd_frame;
        ss_n_d       = 1'b1;
        mosi_d       = 1'b0;
        busy_d       = (state != S_IDLE);
        done_d       = 1'b0;
        rx_valid_d   = 1'b0;
        load_rx      = 1'b0;

        unique case (state)
            S_IDLE: begin
                if (bus.start) begin
                    state_nxt    = S_SEL;
                    tx_sr_nxt    = {bus.cmd, bus.din};
                    rd_frame_nxt = (bus.cmd == 2'b11);
                end
            end
            S_SEL: begin
                ss_n_d    = 1'b0;
                mosi_d    = tx_sr[9];
                state_nxt = S_RW;
            end
            S_RW: begin
                ss_n_d    = 1'b0;
                mosi_d    = tx_sr[9];
                state_nxt = S_SHIFT;
                cnt_nxt   = SHIFT_LOAD;
            end
            S_SHIFT: begin
                ss_n_d    = 1'b0;
                mosi_d    = tx_sr[9];
                tx_sr_nxt = {tx_sr[8:0], 1'b0};
                if (cnt == 4'd0) begin
                    if (rd_frame) begin
                        state_nxt = S_WAIT;
                        cnt_nxt   = WAIT_LOAD;
                    end else begin
                        state_nxt = S_END;
                    end
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            S_WAIT: begin
                ss_n_d = 1'b0;
                if (cnt == 4'd0) begin
                    state_nxt = S_RECV;
                    cnt_nxt   = RECV_LOAD;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            S_RECV: begin
                ss_n_d = 1'b0;
                if (cnt == 4'd0) begin
                    state_nxt = S_END;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            S_END: begin
                done_d     = 1'b1;
                rx_valid_d = rd_frame;
                load_rx    = rd_frame;
                state_nxt  = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Pins lag the state by one edge, so MISO is sampled on the edge after a
    // RECV state; the eighth bit arrives together with the END update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ss_n_q     <= 1'b1;
            mosi_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            rx_valid_q <= 1'b0;
            rx_data_q  <= '0;
            rx_sr      <= '0;
            recv_q     <= 1'b0;
        end else begin
            ss_n_q     <= ss_n_d;
            mosi_q     <= mosi_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            rx_valid_q <= rx_valid_d;
            recv_q     <= (state == S_RECV);
            if (recv_q) begin
                rx_sr <= {rx_sr[5:0], bus.MISO};
            end
            if (load_rx) begin
                rx_data_q <= {rx_sr, bus.MISO};
            end
        end
    end

    assign bus.SS_n     = ss_n_q;
    assign bus.MOSI     = mosi_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.rx_valid = rx_valid_q;
    assign bus.rx_data  = rx_data_q;

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master: frame shape, timing, read-back through a
// behavioural slave+RAM model, ignored starts and mid-frame reset.
module tb_spi_master;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   checks = 0;
    int   errors = 0;

    spi_master_if bus ();
    spi_master_if bus3 ();

    spi_master #(.RD_LAT(1)) u_dut  (.clk(clk), .rst_n(rst_n), .bus(bus.master));
    spi_master #(.RD_LAT(3)) u_dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3.master));

    always #5 clk = ~clk;

    // Behavioural slave+RAM: watches whichever DUT sel3 selects.
    logic       sel3 = 1'b0;
    logic [7:0] mem [256];
    logic [7:0] wr_addr = 8'h00;
    logic [7:0] rd_addr = 8'h00;
    logic [7:0] s_tx = 8'h00;
    logic [8:0] s_bits = 9'h000;
    logic       s_rd = 1'b0;
    logic       s_miso = 1'b0;
    int         s_cnt = 0;
    logic [9:0] s_w;
    int         s_lat;
    logic       s_ss, s_mosi;

    assign s_ss     = sel3 ? bus3.SS_n : bus.SS_n;
    assign s_mosi   = sel3 ? bus3.MOSI : bus.MOSI;
    assign bus.MISO  = s_miso;
    assign bus3.MISO = s_miso;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'hC3;
        mem[8'h33] = 8'h5A;
    end

    always @(posedge clk) begin
        s_lat = sel3 ? 3 : 1;
        if (s_ss) begin
            s_cnt  <= 0;
            s_rd   <= 1'b0;
            s_miso <= 1'b0;
        end else begin
            s_cnt <= s_cnt + 1;
            if (s_cnt >= 2 && s_cnt <= 10) s_bits <= {s_bits[7:0], s_mosi};
            if (s_cnt == 11) begin
                s_w = {s_bits, s_mosi};
                case (s_w[9:8])
                    2'b00: wr_addr <= s_w[7:0];
                    2'b01: mem[wr_addr] = s_w[7:0];
                    2'b10: rd_addr <= s_w[7:0];
                    default: begin
                        s_rd <= 1'b1;
                        s_tx <= mem[rd_addr];
                    end
                endcase
            end
            if (s_rd && s_cnt >= 11 + s_lat && s_cnt < 19 + s_lat) begin
                s_miso <= s_tx[7];
                s_tx   <= {s_tx[6:0], 1'b0};
            end else begin
                s_miso <= 1'b0;
            end
        end
    end

    typedef struct {
        int          low;
        logic [31:0] bits;
        int          first_low;
        int          last_low;
        int          done_cyc;
        int          done_cnt;
        int          rxv_cnt;
        int          rxv_cyc;
        int          busy_cnt;
    } frame_t;

    // Called at a negedge; cycle k is the period after the k-th edge from the start edge.
    task automatic run_frame(input logic use3, input logic [1:0] c, input logic [7:0] d,
                             input int inj_a, input int inj_b, input int tail,
                             output frame_t r);
        int   k;
        logic ss, mo, dn, rv, bz, inj;
        r.low = 0; r.bits = '0; r.first_low = -1; r.last_low = -1; r.done_cyc = -1;
        r.done_cnt = 0; r.rxv_cnt = 0; r.rxv_cyc = -1; r.busy_cnt = 0;
        sel3 = use3;
        if (use3) begin bus3.start = 1'b1; bus3.cmd = c; bus3.din = d; end
        else begin bus.start = 1'b1; bus.cmd = c; bus.din = d; end
        @(posedge clk);
        @(negedge clk);
        if (use3) begin bus3.start = 1'b0; bus3.cmd = ~c; bus3.din = ~d; end
        else begin bus.start = 1'b0; bus.cmd = ~c; bus.din = ~d; end
        k = 0;
        while (k < 64) begin
            ss = use3 ? bus3.SS_n : bus.SS_n;
            mo = use3 ? bus3.MOSI : bus.MOSI;
            dn = use3 ? bus3.done : bus.done;
            rv = use3 ? bus3.rx_valid : bus.rx_valid;
            bz = use3 ? bus3.busy : bus.busy;
            if (!ss) begin
                r.low++;
                r.bits = {r.bits[30:0], mo};
                if (r.first_low < 0) r.first_low = k;
                r.last_low = k;
            end
            if (bz) r.busy_cnt++;
            if (dn) begin r.done_cnt++; if (r.done_cyc < 0) r.done_cyc = k; end
            if (rv) begin r.rxv_cnt++; r.rxv_cyc = k; end
            if (r.done_cyc >= 0 && k == r.done_cyc + tail) break;
            inj = (k == inj_a) || (k == inj_b);
            if (use3) bus3.start = inj; else bus.start = inj;
            @(negedge clk);
            k++;
        end
    endtask

    task automatic test_reset();
        bus.start = 1'b0; bus.cmd = 2'b00; bus.din = 8'h00;
        bus3.start = 1'b0; bus3.cmd = 2'b00; bus3.din = 8'h00;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (bus.SS_n !== 1'b1) begin errors++; $display("FAIL rst_ss_n: got %b expected 1", bus.SS_n); end
        checks++; if (bus.MOSI !== 1'b0) begin errors++; $display("FAIL rst_mosi: got %b expected 0", bus.MOSI); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL rst_done: got %b expected 0", bus.done); end
        checks++; if (bus.rx_valid !== 1'b0) begin errors++; $display("FAIL rst_rx_valid: got %b expected 0", bus.rx_valid); end
        checks++; if (bus.rx_data !== 8'h00) begin errors++; $display("FAIL rst_rx_data: got %h expected 00", bus.rx_data); end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (bus.SS_n !== 1'b1 || bus.busy !== 1'b0) begin
            errors++; $display("FAIL rst_idle: got ss_n=%b busy=%b expected 1/0", bus.SS_n, bus.busy);
        end
    endtask

    task automatic test_write_addr();
        frame_t r;
        run_frame(1'b0, 2'b00, 8'h0F, -1, -1, 2, r);
        checks++; if (r.low !== 12) begin errors++; $display("FAIL wa_low: got %0d expected 12", r.low); end
        checks++; if (r.bits !== 32'h0000_000F) begin errors++; $display("FAIL wa_mosi: got %h expected 0000000f", r.bits); end
        checks++; if (r.first_low !== 1) begin errors++; $display("FAIL wa_first_low: got %0d expected 1", r.first_low); end
        checks++; if (r.done_cyc !== 13) begin errors++; $display("FAIL wa_done_cyc: got %0d expected 13", r.done_cyc); end
        checks++; if (r.done_cnt !== 1) begin errors++; $display("FAIL wa_done_cnt: got %0d expected 1", r.done_cnt); end
        checks++; if (r.rxv_cnt !== 0) begin errors++; $display("FAIL wa_rx_valid: got %0d expected 0", r.rxv_cnt); end
        checks++; if (r.busy_cnt !== 13) begin errors++; $display("FAIL wa_busy: got %0d expected 13", r.busy_cnt); end
    endtask

    task automatic test_back_to_back();
        frame_t r1, r2;
        int     gap;
        run_frame(1'b0, 2'b01, 8'hAA, -1, -1, 0, r1);
        run_frame(1'b0, 2'b10, 8'h0F, -1, -1, 2, r2);
        gap = (r1.done_cyc - r1.last_low) + r2.first_low;
        checks++; if (r1.bits !== 32'h0000_01AA) begin errors++; $display("FAIL b2b_mosi1: got %h expected 000001aa", r1.bits); end
        checks++; if (r1.low !== 12) begin errors++; $display("FAIL b2b_low1: got %0d expected 12", r1.low); end
        checks++; if (r2.bits !== 32'h0000_0E0F) begin errors++; $display("FAIL b2b_mosi2: got %h expected 00000e0f", r2.bits); end
        checks++; if (r2.low !== 12) begin errors++; $display("FAIL b2b_low2: got %0d expected 12", r2.low); end
        checks++; if (gap !== 2) begin errors++; $display("FAIL b2b_gap: got %0d expected 2", gap); end
        checks++; if (r2.done_cyc !== 13) begin errors++; $display("FAIL b2b_done_cyc: got %0d expected 13", r2.done_cyc); end
        checks++; if (mem[8'h0F] !== 8'hAA) begin errors++; $display("FAIL b2b_mem_write: got %h expected aa", mem[8'h0F]); end
        checks++; if (rd_addr !== 8'h0F) begin errors++; $display("FAIL b2b_rd_addr: got %h expected 0f", rd_addr); end
    endtask

    task automatic test_read_data();
        frame_t r;
        run_frame(1'b0, 2'b11, 8'hC3, -1, -1, 2, r);
        checks++; if (r.low !== 21) begin errors++; $display("FAIL rd_low: got %0d expected 21", r.low); end
        checks++; if (r.bits !== 32'h001F_8600) begin errors++; $display("FAIL rd_mosi: got %h expected 001f8600", r.bits); end
        checks++; if (r.done_cyc !== 22) begin errors++; $display("FAIL rd_done_cyc: got %0d expected 22", r.done_cyc); end
        checks++; if (r.done_cnt !== 1) begin errors++; $display("FAIL rd_done_cnt: got %0d expected 1", r.done_cnt); end
        checks++; if (r.rxv_cnt !== 1 || r.rxv_cyc !== 22) begin
            errors++; $display("FAIL rd_rx_valid: got cnt=%0d cyc=%0d expected 1/22", r.rxv_cnt, r.rxv_cyc);
        end
        checks++; if (bus.rx_data !== 8'hAA) begin errors++; $display("FAIL rd_rx_data: got %h expected aa", bus.rx_data); end
    endtask

    task automatic test_read_5a();
        frame_t r;
        run_frame(1'b0, 2'b10, 8'h33, -1, -1, 2, r);
        checks++; if (r.bits !== 32'h0000_0E33) begin errors++; $display("FAIL r5a_addr_mosi: got %h expected 00000e33", r.bits); end
        run_frame(1'b0, 2'b11, 8'hC3, -1, -1, 2, r);
        checks++; if (r.low !== 21) begin errors++; $display("FAIL r5a_low: got %0d expected 21", r.low); end
        checks++; if (bus.rx_data !== 8'h5A) begin errors++; $display("FAIL r5a_rx_data: got %h expected 5a", bus.rx_data); end
        checks++; if (r.rxv_cnt !== 1 || r.done_cnt !== 1) begin
            errors++; $display("FAIL r5a_pulses: got rxv=%0d done=%0d expected 1/1", r.rxv_cnt, r.done_cnt);
        end
    endtask

    task automatic test_read_lat3();
        frame_t r;
        run_frame(1'b1, 2'b10, 8'h33, -1, -1, 2, r);
        checks++; if (r.low !== 12) begin errors++; $display("FAIL l3_addr_low: got %0d expected 12", r.low); end
        run_frame(1'b1, 2'b11, 8'hC3, -1, -1, 2, r);
        checks++; if (r.low !== 23) begin errors++; $display("FAIL l3_low: got %0d expected 23", r.low); end
        checks++; if (r.bits !== 32'h007E_1800) begin errors++; $display("FAIL l3_mosi: got %h expected 007e1800", r.bits); end
        checks++; if (r.done_cyc !== 24) begin errors++; $display("FAIL l3_done_cyc: got %0d expected 24", r.done_cyc); end
        checks++; if (r.rxv_cnt !== 1 || r.rxv_cyc !== 24) begin
            errors++; $display("FAIL l3_rx_valid: got cnt=%0d cyc=%0d expected 1/24", r.rxv_cnt, r.rxv_cyc);
        end
        checks++; if (bus3.rx_data !== 8'h5A) begin errors++; $display("FAIL l3_rx_data: got %h expected 5a", bus3.rx_data); end
    endtask

    task automatic test_start_ignored();
        frame_t r;
        run_frame(1'b0, 2'b00, 8'h0F, 5, 12, 4, r);
        checks++; if (r.done_cnt !== 1) begin errors++; $display("FAIL ign_done_cnt: got %0d expected 1", r.done_cnt); end
        checks++; if (r.low !== 12) begin errors++; $display("FAIL ign_low: got %0d expected 12", r.low); end
        checks++; if (r.bits !== 32'h0000_000F) begin errors++; $display("FAIL ign_mosi: got %h expected 0000000f", r.bits); end
        checks++; if (r.done_cyc !== 13) begin errors++; $display("FAIL ign_done_cyc: got %0d expected 13", r.done_cyc); end
    endtask

    task automatic test_reset_mid();
        frame_t r;
        sel3 = 1'b0;
        bus.start = 1'b1; bus.cmd = 2'b01; bus.din = 8'h66;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (7) @(negedge clk);
        checks++; if (bus.SS_n !== 1'b0 || bus.MOSI !== 1'b1) begin
            errors++; $display("FAIL rm_pre: got ss_n=%b mosi=%b expected 0/1", bus.SS_n, bus.MOSI);
        end
        rst_n = 1'b0;
        #1;
        checks++; if (bus.SS_n !== 1'b1) begin errors++; $display("FAIL rm_ss_n: got %b expected 1", bus.SS_n); end
        checks++; if (bus.MOSI !== 1'b0) begin errors++; $display("FAIL rm_mosi: got %b expected 0", bus.MOSI); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rm_busy: got %b expected 0", bus.busy); end
        checks++; if (bus.rx_data !== 8'h00) begin errors++; $display("FAIL rm_rx_data: got %h expected 00", bus.rx_data); end
        checks++; if (bus3.rx_data !== 8'h00) begin errors++; $display("FAIL rm_rx_data3: got %h expected 00", bus3.rx_data); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_frame(1'b0, 2'b01, 8'h55, -1, -1, 2, r);
        checks++; if (r.bits !== 32'h0000_0155) begin errors++; $display("FAIL rm_mosi_after: got %h expected 00000155", r.bits); end
        checks++; if (r.low !== 12 || r.done_cyc !== 13) begin
            errors++; $display("FAIL rm_frame_after: got low=%0d done=%0d expected 12/13", r.low, r.done_cyc);
        end
        checks++; if (mem[8'h0F] !== 8'h55) begin errors++; $display("FAIL rm_mem: got %h expected 55", mem[8'h0F]); end
    endtask

    initial begin
        test_reset();
        test_write_addr();
        test_back_to_back();
        test_read_data();
        test_read_5a();
        test_read_lat3();
        test_start_ignored();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, errors so far %0d", errors);
        $fatal(1);
    end

endmodule
